// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - Shared types and helpers for the Gray-count receiver
package grey_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } grey_state_e;

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/grey_sync.sv
// rtl/grey_sync.sv - Bitwise two-flop synchroniser for an asynchronous bus
module grey_sync #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta;

  // Two-stage capture; Gray coding keeps each sample within one step of the source.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= '0;
      o_q  <= '0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/grey_rx.sv
// rtl/grey_rx.sv - Gray-count receiver: sync, decode, windowed step count with valid/ready result
// Optional build macro GREYRX_ERRCNT_EN adds the per-window errored-sample counter on o_errcnt.
module grey_rx
  import grey_pkg::*;
#(
  parameter int pCNT_W = CNT_W,
  parameter int pACC_W = 16,
  parameter int pWIN   = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [pCNT_W-1:0] i_grey,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [pACC_W-1:0] o_count,
  output logic              o_sat,
  output logic              o_err,
  output logic              o_ovr,
  output logic [7:0]        o_errcnt
);

  localparam int SUM_W = ((pACC_W > pCNT_W) ? pACC_W : pCNT_W) + 1;
  localparam int WIN_W = $clog2(pWIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(pWIN - 1);
  localparam logic [SUM_W-1:0] ACC_MAX  = SUM_W'({pACC_W{1'b1}});

  logic [pCNT_W-1:0] g_s, g_prev, b_cur, b_prev, delta;
  logic              step_err;
  grey_state_e       state, state_nxt;
  logic              do_clear, do_acc, do_pub;
  logic [WIN_W-1:0]  win_cnt;
  logic [pACC_W-1:0] acc, acc_nxt;
  logic [SUM_W-1:0]  sum;
  logic              acc_sat, acc_err, sat_nxt, err_nxt;
  logic [7:0]        ecnt_nxt;

  grey_sync #(.W(pCNT_W)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_grey),
    .o_q   (g_s)
  );

  assign b_cur    = pCNT_W'(gray2bin(32'(g_s)));
  assign delta    = b_cur - b_prev;
  assign step_err = (popcount(32'(g_s ^ g_prev)) > 6'd1);
  assign sum      = SUM_W'(acc) + SUM_W'(delta);
  assign acc_nxt  = (sum > ACC_MAX) ? '1 : pACC_W'(sum);
  assign sat_nxt  = acc_sat | (sum > ACC_MAX);
  assign err_nxt  = acc_err | step_err;

`ifdef GREYRX_ERRCNT_EN
  logic [7:0] ecnt;

  assign ecnt_nxt = (step_err && ecnt != 8'hFF) ? ecnt + 8'd1 : ecnt;

  // Errored-sample tally for the open window, restarted with the accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ecnt <= '0;
    end else if (do_clear || do_pub) begin
      ecnt <= '0;
    end else if (do_acc) begin
      ecnt <= ecnt_nxt;
    end
  end
`else
  assign ecnt_nxt = 8'd0;
`endif

  // Previous sample tracks every cycle so windows abut without losing a step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      g_prev <= '0;
      b_prev <= '0;
    end else begin
      g_prev <= g_s;
      b_prev <= b_cur;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle window actions; dropping i_en abandons the window.
  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    do_acc    = 1'b0;
    do_pub    = 1'b0;
    case (state)
      ST_IDLE: if (i_en) state_nxt = ST_ARM;
      ST_ARM: begin
        if (!i_en) state_nxt = ST_IDLE;
        else begin
          do_clear  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_en) state_nxt = ST_IDLE;
        else begin
          do_acc = 1'b1;
          do_pub = (win_cnt == WIN_LAST);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Window counter and saturating accumulator; the last cycle hands off and restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_cnt <= '0;
      acc     <= '0;
      acc_sat <= 1'b0;
      acc_err <= 1'b0;
    end else if (do_clear || do_pub) begin
      win_cnt <= '0;
      acc     <= '0;
      acc_sat <= 1'b0;
      acc_err <= 1'b0;
    end else if (do_acc) begin
      win_cnt <= win_cnt + 1'b1;
      acc     <= acc_nxt;
      acc_sat <= sat_nxt;
      acc_err <= err_nxt;
    end
  end

  // Result registers: publish when the slot is free or being emptied, else flag the drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_count  <= '0;
      o_sat    <= 1'b0;
      o_err    <= 1'b0;
      o_errcnt <= '0;
      o_ovr    <= 1'b0;
    end else if (do_pub) begin
      if (!o_valid || i_ready) begin
        o_valid  <= 1'b1;
        o_count  <= acc_nxt;
        o_sat    <= sat_nxt;
        o_err    <= err_nxt;
        o_errcnt <= ecnt_nxt;
      end else begin
        o_ovr <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grey_rx.sv
// tb/tb_grey_rx.sv - Randomised self-checking bench for grey_rx against a history-based model
module tb_grey_rx;

  localparam int WIN   = 1024;
  localparam int WIN_S = 32;
`ifdef GREYRX_ERRCNT_EN
  localparam bit ECNT_ON = 1'b1;
`else
  localparam bit ECNT_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        en = 1'b0, ready = 1'b0, en_s = 1'b0, ready_s = 1'b0;
  logic [4:0]  grey = 5'd0;
  logic        valid, sat, err, ovr, valid_s, sat_s, err_s, ovr_s;
  logic [15:0] count;
  logic [3:0]  count_s;
  logic [7:0]  errcnt, errcnt_s;

  int n_chk = 0, n_err = 0, cyc = 0;
  logic [4:0] gv [0:65535];
  int src_per = 0, phase = 0, src_pos = 0;
  logic [4:0] grey_raw = 5'd0;
  bit glitch_en = 1'b0;

  grey_rx dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_grey(grey), .o_valid(valid), .i_ready(ready),
    .o_count(count), .o_sat(sat), .o_err(err), .o_ovr(ovr), .o_errcnt(errcnt)
  );

  grey_rx #(.pACC_W(4), .pWIN(WIN_S)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en_s), .i_grey(grey), .o_valid(valid_s), .i_ready(ready_s),
    .o_count(count_s), .o_sat(sat_s), .o_err(err_s), .o_ovr(ovr_s), .o_errcnt(errcnt_s)
  );

  always #5 clk = ~clk;

  // Edge-indexed history of the Gray value presented at each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < 65536) gv[cyc] = grey;
  end

  // Gray source: steps every src_per clocks, optional random glitches, or a raw held value.
  always @(negedge clk) begin
    if (src_per != 0) begin
      phase = phase + 1;
      if (phase >= src_per) begin
        phase   = 0;
        src_pos = (src_pos + 1) % 32;
      end
      grey = 5'(src_pos ^ (src_pos >> 1));
      if (glitch_en && $urandom_range(0, 299) == 0) grey = 5'($urandom);
    end else begin
      grey = grey_raw;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  function automatic int bin5(input logic [4:0] g);
    return int'(g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4));
  endfunction

  // A window of n edges ending at edge p; the sample used at edge k was presented at edge k-2.
  function automatic void model(input int p, input int n, input int accw,
                                output int cnt, output int sat_o, output int err_o, output int ecnt);
    int mx, d;
    mx = (1 << accw) - 1;
    cnt = 0; sat_o = 0; err_o = 0; ecnt = 0;
    for (int k = p - n + 1; k <= p; k++) begin
      d = (bin5(gv[k-2]) - bin5(gv[k-3])) & 31;
      if ($countones(gv[k-2] ^ gv[k-3]) > 1) begin
        err_o = 1;
        if (ecnt < 255) ecnt++;
      end
      if (cnt + d > mx) begin
        cnt = mx;
        sat_o = 1;
      end else begin
        cnt = cnt + d;
      end
    end
  endfunction

  task automatic check_win(input string tag, input int p, output int cnt);
    int s, e, ec;
    model(p, WIN, 16, cnt, s, e, ec);
    check({tag, "_valid"}, 32'(valid), 1);
    check({tag, "_count"}, 32'(count), cnt);
    check({tag, "_sat"}, 32'(sat), s);
    check({tag, "_err"}, 32'(err), e);
    check({tag, "_errcnt"}, 32'(errcnt), ECNT_ON ? ec : 0);
  endtask

  initial begin
    int p1, p2, p3, p4, p5, ps, c0, w1cnt, tmp, m_s, m_e, m_ec, guard;
    bit seen;

    // reset state
    step(); step();
    check("rst_valid", 32'(valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_flags", {29'd0, sat, err, ovr}, 0);
    check("rst_errcnt", 32'(errcnt), 0);
    check("rst_valid_s", 32'(valid_s), 0);
    rst = 1'b0;
    src_pos = int'($urandom_range(0, 31));
    src_per = 4;
    repeat (6) step();

    // first window: one step per 4 clocks
    en = 1'b1;
    c0 = cyc;
    p1 = c0 + 3 + WIN - 1;
    run_to(p1 - 1);
    check("w1_early", 32'(valid), 0);
    run_to(p1);
    check_win("w1", p1, w1cnt);
    check("w1_256", 32'(count), 256);

    // second window unread: dropped, first result kept
    src_per = int'($urandom_range(1, 3));
    p2 = p1 + WIN;
    run_to(p2 - 1);
    check("w2_ovr_pre", 32'(ovr), 0);
    run_to(p2);
    check("w2_ovr", 32'(ovr), 1);
    check("w2_valid", 32'(valid), 1);
    check("w2_kept", 32'(count), w1cnt);

    // accept
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("acc_valid", 32'(valid), 0);
    check("acc_ovr", 32'(ovr), 1);

    // third window: wrap into 00000 then illegal jump 00000 -> 00011
    src_per = 4;
    guard = 0;
    while (grey != 5'd0 && guard < 300) begin
      step();
      guard++;
    end
    check("inj_found_zero", 32'(grey), 0);
    grey_raw = 5'd0;
    src_per = 0;
    repeat (4) step();
    grey_raw = 5'b00011;
    repeat (4) step();
    src_pos = 2;
    phase = 0;
    src_per = 4;
    p3 = p2 + WIN;
    run_to(p3);
    check_win("w3", p3, tmp);
    check("w3_err", 32'(err), 1);
    check("w3_errcnt", 32'(errcnt), ECNT_ON ? 1 : 0);
    ready = 1'b1;
    step();
    ready = 1'b0;

    // enable dropped mid-window: no result
    run_to(p3 + 500);
    en = 1'b0;
    seen = 1'b0;
    while (cyc < p3 + WIN + 20) begin
      step();
      if (valid) seen = 1'b1;
    end
    check("drop_no_valid", 32'(seen), 0);
    en = 1'b1;
    p4 = cyc + 3 + WIN - 1;
    run_to(p4 - 1);
    check("reen_early", 32'(valid), 0);
    run_to(p4);
    check_win("reen", p4, tmp);

    // async reset mid-window with a result pending
    run_to(p4 + 300);
    check("pre_rst_valid", 32'(valid), 1);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_ovr", 32'(ovr), 0);
    check("arst_flags", {30'd0, sat, err}, 0);
    step(); step();
    rst = 1'b0;
    repeat (4) step();
    en = 1'b1;
    p5 = cyc + 3 + WIN - 1;
    run_to(p5 - 1);
    check("post_rst_early", 32'(valid), 0);
    run_to(p5);
    check_win("post_rst", p5, tmp);

    // narrow accumulator saturates with a step every clock
    ready = 1'b1;
    ready_s = 1'b1;
    src_per = 1;
    repeat (3) step();
    en_s = 1'b1;
    ps = cyc + 3 + WIN_S - 1;
    run_to(ps - 1);
    check("sat_early", 32'(valid_s), 0);
    run_to(ps);
    model(ps, WIN_S, 4, tmp, m_s, m_e, m_ec);
    check("sat_valid", 32'(valid_s), 1);
    check("sat_count", 32'(count_s), tmp);
    check("sat_count15", 32'(count_s), 15);
    check("sat_flag", 32'(sat_s), 1);
    check("sat_err", 32'(err_s), 0);
    en_s = 1'b0;

    // random rates with occasional glitches, results accepted as they arrive
    glitch_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      src_per = int'($urandom_range(1, 7));
      run_to(p5 + k * WIN - 1);
      check("rnd_early", 32'(valid), 0);
      run_to(p5 + k * WIN);
      check_win("rnd", p5 + k * WIN, tmp);
    end
    glitch_en = 1'b0;
    check("final_ovr", 32'(ovr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
